// File: rtl/icache_refill_fetcher_pkg.sv
// Shared definitions for the instruction-fetch refill path: fetch FSM state
// encoding, datapath width and the number of bytes in one instruction word.
package icache_refill_fetcher_pkg;

    localparam int XLEN           = 32;
    localparam int BYTES_PER_INST = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_INST);
    localparam int WORD_W         = 8 * BYTES_PER_INST;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MISS  = 2'd2,
        FILL  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/icache_refill_fetcher_byte_assembler.sv
// Byte assembler for cache refills: collects bytes arriving from the
// byte-wide memory port into a little-endian word (first byte -> bits 7:0).
// done flags that the byte being loaded this cycle completes the word;
// next_word is the word including that byte, so the caller can capture it
// on the same edge the byte lands.
module icache_refill_fetcher_byte_assembler
    import icache_refill_fetcher_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [7:0]            data,
    output logic [BYTE_IDX_W-1:0] count,
    output logic [WORD_W-1:0]     word,
    output logic [WORD_W-1:0]     next_word,
    output logic                  done
);

    // Insert the incoming byte at the lane selected by the byte counter.
    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_word = word;
        next_word[{count, 3'b000} +: 8] = data;
    end

    assign done = load && (count == BYTE_IDX_W'(BYTES_PER_INST - 1));

    // Counter and buffer; clear wins over load, everything frozen when en is low.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
            word  <= '0;
        end else if (en) begin
            if (clear) begin
                count <= '0;
                word  <= '0;
            end else if (load) begin
                count <= count + BYTE_IDX_W'(1);
                word  <= next_word;
            end
        end
    end

endmodule

// File: rtl/icache_refill_fetcher.sv
// Fetch-side initiator for the direct-mapped instruction cache. Probes the
// cache with the accepted PC; on a hit returns the cached word, on a miss
// reads four bytes from the memory port, writes the assembled word into the
// cache and returns it. flush cancels whatever is in flight.
// Build option: define ICACHE_FETCH_PERF_EN to add hit_count/miss_count.
module icache_refill_fetcher #(
    parameter int XLEN = icache_refill_fetcher_pkg::XLEN   // only 32 supported
`ifdef ICACHE_FETCH_PERF_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] cache_addr,
    output logic            cache_wr,
    output logic [XLEN-1:0] cache_value,
    input  logic            cache_hit,
    input  logic [XLEN-1:0] cache_result,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [7:0]      mem_data
`ifdef ICACHE_FETCH_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
`endif
);
    import icache_refill_fetcher_pkg::*;

    fetch_state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            cache_wr_q, cache_wr_d;
    logic [XLEN-1:0] inst_out_q, inst_out_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] cache_value_q, cache_value_d;

    logic                  asm_clear;
    logic                  asm_load;
    logic [BYTE_IDX_W-1:0] asm_count;
    logic [WORD_W-1:0]     asm_word;
    logic [WORD_W-1:0]     asm_next_word;
    logic                  asm_done;

    icache_refill_fetcher_byte_assembler u_byte_assembler (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en        (rdy_in),
        .clear     (asm_clear),
        .load      (asm_load),
        .data      (mem_data),
        .count     (asm_count),
        .word      (asm_word),
        .next_word (asm_next_word),
        .done      (asm_done)
    );

    // Next-state and registered-output decode; flush overrides every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_valid_d  = 1'b0;
        cache_wr_d    = 1'b0;
        inst_out_d    = inst_out_q;
        inst_pc_d     = inst_pc_q;
        cache_value_d = cache_value_q;
        asm_clear     = 1'b0;
        asm_load      = 1'b0;

        if (flush) begin
            // Any byte returned this cycle is dropped and the partial word discarded.
            state_d   = IDLE;
            asm_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_valid) begin
                        pc_d    = fetch_pc & ~XLEN'(3);
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (cache_hit) begin
                        inst_valid_d = 1'b1;
                        inst_out_d   = cache_result;
                        inst_pc_d    = pc_q;
                        state_d      = IDLE;
                    end else begin
                        asm_clear = 1'b1;
                        state_d   = MISS;
                    end
                end
                MISS: begin
                    if (mem_ready) begin
                        asm_load = 1'b1;
                        if (asm_done) begin
                            // Launch the FILL pulses with the completed word.
                            inst_valid_d  = 1'b1;
                            cache_wr_d    = 1'b1;
                            inst_out_d    = asm_next_word;
                            cache_value_d = asm_next_word;
                            inst_pc_d     = pc_q;
                            state_d       = FILL;
                        end
                    end
                end
                FILL:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            inst_valid_q  <= 1'b0;
            cache_wr_q    <= 1'b0;
            inst_out_q    <= '0;
            inst_pc_q     <= '0;
            cache_value_q <= '0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_valid_q  <= inst_valid_d;
            cache_wr_q    <= cache_wr_d;
            inst_out_q    <= inst_out_d;
            inst_pc_q     <= inst_pc_d;
            cache_value_q <= cache_value_d;
        end
    end

    // A flush in the pulse cycle itself squashes the delivery and the write.
    assign inst_valid  = inst_valid_q && !(rdy_in && flush);
    assign cache_wr    = cache_wr_q && !(rdy_in && flush);
    assign inst_out    = inst_out_q;
    assign inst_pc     = inst_pc_q;
    assign cache_value = cache_value_q;
    assign fetch_ready = (state_q == IDLE);
    assign cache_addr  = (state_q == IDLE) ? '0 : pc_q;
    assign mem_req     = (state_q == MISS);
    assign mem_addr    = (state_q == MISS) ? pc_q + XLEN'(asm_count) : '0;

`ifdef ICACHE_FETCH_PERF_EN
    logic hit_evt;
    logic miss_evt;

    assign hit_evt  = rdy_in && !flush && (state_q == CHECK) && cache_hit;
    assign miss_evt = rdy_in && !flush && (state_q == CHECK) && !cache_hit;

    // Lookup outcome counters, wrapping at 2^CNT_WIDTH.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt)  hit_count  <= hit_count + CNT_WIDTH'(1);
            if (miss_evt) miss_count <= miss_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_fetcher.sv
// Self-checking bench for icache_refill_fetcher: a directed vector table for
// the miss/hit/address-wrap flows, hand-written multi-cycle corner cases
// (reset mid-refill, flush, rdy_in stall) and a randomized run checked
// against a phase-based reference model.
module tb_icache_refill_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] cache_addr;
    logic        cache_wr;
    logic [31:0] cache_value;
    logic        cache_hit;
    logic [31:0] cache_result;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;
`ifdef ICACHE_FETCH_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    icache_refill_fetcher dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .cache_addr   (cache_addr),
        .cache_wr     (cache_wr),
        .cache_value  (cache_value),
        .cache_hit    (cache_hit),
        .cache_result (cache_result),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data)
`ifdef ICACHE_FETCH_PERF_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] res;
        logic        mr;
        logic [7:0]  md;
        logic        e_fr;
        logic        e_req;
        logic [31:0] e_maddr;
        logic [31:0] e_caddr;
        logic        e_iv;
        logic        e_wr;
        logic [31:0] e_out;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic fv, logic [31:0] pc, logic hit, logic [31:0] res,
                                logic mr, logic [7:0] md, logic e_fr, logic e_req,
                                logic [31:0] e_maddr, logic [31:0] e_caddr, logic e_iv,
                                logic e_wr, logic [31:0] e_out, logic [31:0] e_ipc);
        vec_t v;
        v.fv = fv; v.pc = pc; v.hit = hit; v.res = res; v.mr = mr; v.md = md;
        v.e_fr = e_fr; v.e_req = e_req; v.e_maddr = e_maddr; v.e_caddr = e_caddr;
        v.e_iv = e_iv; v.e_wr = e_wr; v.e_out = e_out; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic fv, input logic [31:0] pc, input logic hit,
                          input logic [31:0] res, input logic mr, input logic [7:0] md);
        fetch_valid  = fv;
        fetch_pc     = pc;
        cache_hit    = hit;
        cache_result = res;
        mem_ready    = mr;
        mem_data     = md;
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic apply_reset();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        flush  = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        repeat (2) next_cycle();
        rst_in = 1'b1;
    endtask

    // From IDLE: accept pc, report a miss; returns with the DUT in its byte-read phase.
    task automatic start_miss(input logic [31:0] pc);
        set_in(1'b1, pc, 1'b0, 32'h0, 1'b0, 8'h0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        next_cycle();
    endtask

    task automatic feed_byte(input logic [7:0] b);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, b);
        next_cycle();
    endtask

    // Reference model: phase 0 idle, 1 lookup, 2..5 waiting for byte (phase-2), 6 write-back.
    int          m_phase;
    logic [31:0] m_pc, m_word, m_out, m_opc, m_cval;
    logic        m_pv, m_pw;
    int unsigned m_hits, m_misses;

    task automatic model_reset();
        m_phase = 0; m_pc = 0; m_word = 0; m_out = 0; m_opc = 0; m_cval = 0;
        m_pv = 0; m_pw = 0; m_hits = 0; m_misses = 0;
    endtask

    task automatic model_check();
        logic squash;
        logic [31:0] e_maddr;
        squash  = rdy_in && flush;
        e_maddr = (m_phase >= 2 && m_phase <= 5) ? m_pc + 32'(m_phase - 2) : 32'h0;
        check("rnd fetch_ready", {31'b0, fetch_ready}, {31'b0, m_phase == 0});
        check("rnd mem_req", {31'b0, mem_req}, {31'b0, m_phase >= 2 && m_phase <= 5});
        check("rnd mem_addr", mem_addr, e_maddr);
        check("rnd cache_addr", cache_addr, (m_phase == 0) ? 32'h0 : m_pc);
        check("rnd inst_valid", {31'b0, inst_valid}, {31'b0, m_pv && !squash});
        check("rnd cache_wr", {31'b0, cache_wr}, {31'b0, m_pw && !squash});
        check("rnd inst_out", inst_out, m_out);
        check("rnd inst_pc", inst_pc, m_opc);
        if (m_pw && !squash) check("rnd cache_value", cache_value, m_cval);
    endtask

    task automatic model_step();
        if (!rdy_in) return;
        m_pv = 0;
        m_pw = 0;
        if (flush) begin
            m_phase = 0;
            m_word  = 0;
        end else if (m_phase == 0) begin
            if (fetch_valid) begin
                m_pc    = {fetch_pc[31:2], 2'b00};
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (cache_hit) begin
                m_pv = 1; m_out = cache_result; m_opc = m_pc; m_phase = 0; m_hits++;
            end else begin
                m_word = 0; m_phase = 2; m_misses++;
            end
        end else if (m_phase <= 5) begin
            if (mem_ready) begin
                m_word = m_word | (32'(mem_data) << (8 * (m_phase - 2)));
                if (m_phase == 5) begin
                    m_pv = 1; m_pw = 1; m_out = m_word; m_cval = m_word; m_opc = m_pc;
                    m_phase = 6;
                end else begin
                    m_phase++;
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    initial begin
        fetch_pc = 0;
        apply_reset();

        // ---- reset state (checked while reset is still asserted) ----
        rst_in = 1'b0;
        #1;
        check("reset fetch_ready", {31'b0, fetch_ready}, 32'd1);
        check("reset inst_valid", {31'b0, inst_valid}, 32'd0);
        check("reset cache_wr", {31'b0, cache_wr}, 32'd0);
        check("reset mem_req", {31'b0, mem_req}, 32'd0);
        check("reset inst_out", inst_out, 32'h0);
        check("reset cache_addr", cache_addr, 32'h0);
        rst_in = 1'b1;
        next_cycle();

        // ---- directed table: miss at 0x1000, hit at 0x1000, miss at 0xFFFF_FFFC ----
        vecs[0]  = mk(1, 32'h1000, 0, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 32'h0, 0, 0, 0, 8'h00, 0, 0, 32'h0, 32'h1000, 0, 0, 32'h0, 32'h0);
        vecs[2]  = mk(0, 32'h0, 0, 0, 1, 8'h13, 0, 1, 32'h1000, 32'h1000, 0, 0, 32'h0, 32'h0);
        vecs[3]  = mk(0, 32'h0, 0, 0, 0, 8'h00, 0, 1, 32'h1001, 32'h1000, 0, 0, 32'h0, 32'h0);
        vecs[4]  = mk(0, 32'h0, 0, 0, 1, 8'h05, 0, 1, 32'h1001, 32'h1000, 0, 0, 32'h0, 32'h0);
        vecs[5]  = mk(0, 32'h0, 0, 0, 1, 8'h10, 0, 1, 32'h1002, 32'h1000, 0, 0, 32'h0, 32'h0);
        vecs[6]  = mk(0, 32'h0, 0, 0, 1, 8'h00, 0, 1, 32'h1003, 32'h1000, 0, 0, 32'h0, 32'h0);
        vecs[7]  = mk(0, 32'h0, 0, 0, 0, 8'h00, 0, 0, 32'h0, 32'h1000, 1, 1, 32'h0010_0513, 32'h1000);
        vecs[8]  = mk(1, 32'h1000, 0, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[9]  = mk(0, 32'h0, 1, 32'h0010_0513, 0, 8'h00, 0, 0, 32'h0, 32'h1000, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[10] = mk(0, 32'h0, 0, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0, 1, 0, 32'h0010_0513, 32'h1000);
        vecs[11] = mk(0, 32'h0, 0, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[12] = mk(1, 32'hFFFF_FFFD, 0, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[13] = mk(0, 32'h0, 0, 0, 0, 8'h00, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[14] = mk(0, 32'h0, 0, 0, 1, 8'hAA, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[15] = mk(0, 32'h0, 0, 0, 1, 8'hBB, 0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[16] = mk(0, 32'h0, 0, 0, 1, 8'hCC, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[17] = mk(0, 32'h0, 0, 0, 1, 8'hDD, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 0, 32'h0010_0513, 32'h1000);
        vecs[18] = mk(0, 32'h0, 0, 0, 0, 8'h00, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 1, 32'hDDCC_BBAA, 32'hFFFF_FFFC);
        vecs[19] = mk(0, 32'h0, 0, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0, 0, 0, 32'hDDCC_BBAA, 32'hFFFF_FFFC);

        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].fv, vecs[i].pc, vecs[i].hit, vecs[i].res, vecs[i].mr, vecs[i].md);
            sample();
            check($sformatf("vec%0d fetch_ready", i), {31'b0, fetch_ready}, {31'b0, vecs[i].e_fr});
            check($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
            check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
            check($sformatf("vec%0d cache_addr", i), cache_addr, vecs[i].e_caddr);
            check($sformatf("vec%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_iv});
            check($sformatf("vec%0d cache_wr", i), {31'b0, cache_wr}, {31'b0, vecs[i].e_wr});
            check($sformatf("vec%0d inst_out", i), inst_out, vecs[i].e_out);
            check($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
            if (vecs[i].e_wr) check($sformatf("vec%0d cache_value", i), cache_value, vecs[i].e_out);
            next_cycle();
        end
`ifdef ICACHE_FETCH_PERF_EN
        check("table hit_count", hit_count, 32'd1);
        check("table miss_count", miss_count, 32'd2);
`endif

        // ---- reset in the middle of a refill, after two bytes ----
        start_miss(32'h4000);
        feed_byte(8'h11);
        feed_byte(8'h22);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        sample();
        check("mid-miss mem_addr", mem_addr, 32'h4002);
        rst_in = 1'b0;
        #1;
        check("rst-mid fetch_ready", {31'b0, fetch_ready}, 32'd1);
        check("rst-mid mem_req", {31'b0, mem_req}, 32'd0);
        check("rst-mid cache_wr", {31'b0, cache_wr}, 32'd0);
        check("rst-mid inst_valid", {31'b0, inst_valid}, 32'd0);
        next_cycle();
        rst_in = 1'b1;
        start_miss(32'h4000);
        sample();
        check("refetch first mem_addr", mem_addr, 32'h4000);
        next_cycle();
        feed_byte(8'h01);
        feed_byte(8'h02);
        feed_byte(8'h03);
        feed_byte(8'h04);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        sample();
        check("refetch inst_valid", {31'b0, inst_valid}, 32'd1);
        check("refetch cache_wr", {31'b0, cache_wr}, 32'd1);
        check("refetch word", inst_out, 32'h0403_0201);
        check("refetch cache_value", cache_value, 32'h0403_0201);
        next_cycle();

        // ---- flush in place of the 4th byte at 0x2000, then fetch 0x3000 ----
        start_miss(32'h2000);
        feed_byte(8'h55);
        feed_byte(8'h66);
        feed_byte(8'h77);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'h88);
        flush = 1'b1;
        sample();
        check("flush-cyc mem_addr", mem_addr, 32'h2003);
        check("flush-cyc inst_valid", {31'b0, inst_valid}, 32'd0);
        next_cycle();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        sample();
        check("post-flush fetch_ready", {31'b0, fetch_ready}, 32'd1);
        check("post-flush mem_req", {31'b0, mem_req}, 32'd0);
        check("post-flush inst_valid", {31'b0, inst_valid}, 32'd0);
        check("post-flush cache_wr", {31'b0, cache_wr}, 32'd0);
        start_miss(32'h3000);
        sample();
        check("after-flush first mem_addr", mem_addr, 32'h3000);
        next_cycle();
        feed_byte(8'h9A);
        feed_byte(8'hBC);
        feed_byte(8'hDE);
        feed_byte(8'hF0);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        sample();
        check("after-flush cache_wr", {31'b0, cache_wr}, 32'd1);
        check("after-flush word", inst_out, 32'hF0DE_BC9A);
        check("after-flush inst_pc", inst_pc, 32'h3000);
        next_cycle();

        // ---- flush on the lookup cycle of a hit suppresses the delivery ----
        set_in(1'b1, 32'h6000, 1'b0, 32'h0, 1'b0, 8'h0);
        next_cycle();
        set_in(1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h0);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        sample();
        check("flushed-hit inst_valid", {31'b0, inst_valid}, 32'd0);
        check("flushed-hit fetch_ready", {31'b0, fetch_ready}, 32'd1);
        next_cycle();

        // ---- rdy_in low for 5 cycles mid-refill with mem_ready pulsing ----
        start_miss(32'h5000);
        feed_byte(8'h11);
        for (int i = 0; i < 5; i++) begin
            rdy_in = 1'b0;
            set_in(1'b0, 32'h0, 1'b0, 32'h0, (i % 2) == 0, 8'hEE);
            sample();
            check($sformatf("stall%0d mem_req", i), {31'b0, mem_req}, 32'd1);
            check($sformatf("stall%0d mem_addr", i), mem_addr, 32'h5001);
            next_cycle();
        end
        rdy_in = 1'b1;
        feed_byte(8'h22);
        feed_byte(8'h33);
        feed_byte(8'h44);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h0);
        sample();
        check("stall word", inst_out, 32'h4433_2211);
        check("stall cache_wr", {31'b0, cache_wr}, 32'd1);
        next_cycle();

        // ---- randomized run against the reference model ----
        apply_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy_in       = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 29) == 0);
            fetch_valid  = $urandom_range(0, 1) == 1;
            fetch_pc     = $urandom;
            cache_hit    = $urandom_range(0, 1) == 1;
            cache_result = $urandom;
            mem_ready    = $urandom_range(0, 1) == 1;
            mem_data     = 8'($urandom);
            sample();
            model_check();
            model_step();
            next_cycle();
        end
`ifdef ICACHE_FETCH_PERF_EN
        check("rnd hit_count", hit_count, m_hits);
        check("rnd miss_count", miss_count, m_misses);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_refill_fetcher.md
Name: icache_refill_fetcher

Overview:
- Fetch-side initiator for the direct-mapped instruction cache. Accepts a PC from the front end, probes the cache, and returns the instruction on a hit.
- On a miss it reads 4 bytes from the byte-wide memory port and assembles a little-endian word. It then writes the word into the cache (drives wr/addr/value) and returns it to the front end.
- Sits between the instruction queue/PC logic and the memory arbiter.

Parameters:
- XLEN, 32, address and instruction width; only 32 is supported.
- CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global ready; all state frozen when low
- flush  input  1  cancel the current fetch (branch mispredict)
- fetch_valid  input  1  front end requests fetch at fetch_pc
- fetch_pc  input  32  fetch address, word aligned
- fetch_ready  output  1  high in IDLE only; request accepted on fetch_valid&&fetch_ready
- inst_valid  output  1  one-cycle pulse, instruction ready
- inst_out  output  32  instruction word
- inst_pc  output  32  PC of inst_out
- cache_addr  output  32  address to cache (lookup and write)
- cache_wr  output  1  cache write strobe
- cache_value  output  32  word to write
- cache_hit  input  1  combinational hit for cache_addr
- cache_result  input  32  combinational data for cache_addr
- mem_req  output  1  byte read request, held until mem_ready
- mem_addr  output  32  byte address
- mem_ready  input  1  byte returned this cycle
- mem_data  input  8  returned byte

Behaviour:
- Reset (rst_in=0, async): state=IDLE; all outputs 0 except fetch_ready=1; byte counter=0; assembly buffer=0.
- rdy_in=0: no register changes; outputs hold; mem_ready ignored.
- States: IDLE, CHECK, MISS, FILL.
- IDLE: on fetch_valid, latch pc=fetch_pc, go to CHECK. cache_addr=pc register in all non-IDLE states.
- CHECK:
  - cache_hit=1: next cycle inst_valid=1, inst_out=cache_result, inst_pc=pc; go to IDLE.
  - Hit latency: 2 cycles from acceptance to inst_valid.
  - Miss: go to MISS with byte counter=0.
- MISS:
  - mem_req=1, mem_addr=pc+counter (counter 0..3).
  - On mem_ready, store mem_data into buffer byte [counter] (byte 0 = bits 7:0), increment counter.
  - After the 4th byte go to FILL. mem_req drops the cycle after the 4th byte.
- FILL (one cycle):
  - cache_wr=1, cache_value=buffer, cache_addr=pc.
  - Same cycle: inst_valid=1, inst_out=buffer, inst_pc=pc. Go to IDLE.
- inst_valid and cache_wr are registered single-cycle pulses; never asserted together outside FILL.
- flush (highest priority, any state, rdy_in=1):
  - Next state IDLE; counter cleared; no inst_valid or cache_wr that cycle.
  - A mem_ready arriving in the flush cycle is discarded.
  - fetch_valid in the same cycle as flush is ignored.
- Partially assembled words are never written to the cache.
- mem_addr addition wraps modulo 2^32.
- fetch_pc[1:0] is ignored (treated as 0).

Optional Feature:
- Macro ICACHE_FETCH_PERF_EN.
- Defined: extra outputs hit_count and miss_count [CNT_WIDTH-1:0]. Incremented on CHECK hit and CHECK miss respectively; flush does not decrement; wrap at 2^CNT_WIDTH; cleared by reset.
- Undefined: ports and counters absent; otherwise identical behaviour.

Decomposition:
- Shared package: state encoding constants (IDLE/CHECK/MISS/FILL), XLEN, BYTES_PER_INST=4.
- Natural sub-module: byte_assembler (counter + 4-byte shift/insert buffer with clear and done flag).

Test Plan:
- Reset mid-MISS after 2 bytes -> fetch_ready=1, mem_req=0, counter=0, no cache_wr; refetch works normally.
- Miss: fetch_pc=0x0000_1000, cache_hit=0, memory returns 0x13,0x05,0x10,0x00 -> mem_addr sequence 0x1000..0x1003; FILL pulse with cache_wr=1, cache_value=inst_out=0x0010_0513, inst_pc=0x1000.
- Hit: same PC again with cache_hit=1, cache_result=0x0010_0513 -> inst_valid 2 cycles after acceptance, no mem_req.
- Flush after 3rd byte at PC 0x2000 -> IDLE next cycle, no cache_wr/inst_valid. Following fetch at 0x3000 issues mem_addr 0x3000 first.
- rdy_in low for 5 cycles during MISS with mem_ready pulsing -> bytes ignored, counter unchanged, mem_addr held.
- PC 0xFFFF_FFFC miss -> mem_addr 0xFFFF_FFFC..0xFFFF_FFFF, no wrap glitch. With ICACHE_FETCH_PERF_EN: miss_count=1, hit_count=0.
